// File: rtl/cordic_req_scheduler.sv
// cordic_req_scheduler
// ---------------------------------------------------------------------------
// Purpose: lets two requesters share one fixed-latency CORDIC core. A
// round-robin arbiter grants at most one request per cycle. The granted
// operands are registered onto the core input. The requester ID travels
// alongside the core in a tag shift register, so that each core result is
// routed back to the requester that issued it.
//
// Optional feature: define CORDIC_SCHED_TAG_CHECK_EN to enable the sticky
// tag_err flag. The flag sets when a core result arrives with no matching
// tag, or when a tag reaches the tail with no core result. When the macro is
// undefined, tag_err is tied to 0.
//
// Ports:
//   clk, rst               clock (rising edge); asynchronous active-low reset
//   req_valid/req_ready    per-requester handshake (ready is combinational)
//   req{0,1}_degree/x/y    operands; req_arctan_en selects vectoring mode
//   core_valid, core_*     registered issue strobe, mode and operands to the core
//   core_valid_out, core_res_*  result strobe and results from the core
//   rsp_valid, rsp_*       registered per-requester result strobe and shared data
//   drain                  stop granting; idle = nothing in flight or issuing
//   tag_err                sticky result/tag mismatch flag
// ---------------------------------------------------------------------------
module cordic_req_scheduler #(
  parameter int DATA_WIDTH   = 16,
  parameter int CORE_LATENCY = 8,
  parameter int CNT_WIDTH    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [DATA_WIDTH-1:0] req0_degree,
  input  logic [DATA_WIDTH-1:0] req0_x,
  input  logic [DATA_WIDTH-1:0] req0_y,
  input  logic [DATA_WIDTH-1:0] req1_degree,
  input  logic [DATA_WIDTH-1:0] req1_x,
  input  logic [DATA_WIDTH-1:0] req1_y,
  input  logic [1:0]            req_arctan_en,
  output logic                  core_valid,
  output logic                  core_arctan_en,
  output logic [DATA_WIDTH-1:0] core_degree,
  output logic [DATA_WIDTH-1:0] core_x,
  output logic [DATA_WIDTH-1:0] core_y,
  input  logic                  core_valid_out,
  input  logic [DATA_WIDTH-1:0] core_res_x,
  input  logic [DATA_WIDTH-1:0] core_res_y,
  input  logic [DATA_WIDTH-1:0] core_res_degree,
  output logic [1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_x,
  output logic [DATA_WIDTH-1:0] rsp_y,
  output logic [DATA_WIDTH-1:0] rsp_degree,
  input  logic                  drain,
  output logic                  idle,
  output logic                  tag_err
);

  typedef enum logic {ST_RUN, ST_DRAIN} state_t;

  state_t                  state_q, state_d;
  logic                    last_grant_q;
  logic                    sel_valid, sel_id, ready_en, xfer;
  logic                    core_valid_q, core_arctan_q, core_id_q;
  logic [DATA_WIDTH-1:0]   core_degree_q, core_x_q, core_y_q;
  logic [CORE_LATENCY-1:0] tag_vld_q, tag_id_q;
  logic                    tail_vld, tail_id, rsp_hit;
  logic [1:0]              rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_x_q, rsp_y_q, rsp_degree_q;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

  // Arbiter: with both requesters valid, the one not granted last wins.
  // With a single valid requester, that requester wins immediately.
  always_comb begin
    sel_valid = |req_valid;
    if (&req_valid) sel_id = ~last_grant_q;
    else            sel_id = req_valid[1];
  end

  // Gating with rst keeps ready low while reset is asserted, even though
  // the state register already reads RUN.
  assign ready_en     = rst && (state_q == ST_RUN) && !drain && sel_valid;
  assign req_ready[0] = ready_en && !sel_id;
  assign req_ready[1] = ready_en &&  sel_id;
  assign xfer         = |(req_valid & req_ready);

  assign tail_vld = tag_vld_q[CORE_LATENCY-1];
  assign tail_id  = tag_id_q[CORE_LATENCY-1];
  assign rsp_hit  = core_valid_out && tail_vld;

  // In-flight count: +1 per transfer, -1 per tag that leaves the tail.
  // A tail tag leaves whether or not the core delivered a result.
  always_comb begin
    cnt_d = cnt_q;
    if (xfer && !tail_vld)      cnt_d = cnt_q + CNT_WIDTH'(1);
    else if (!xfer && tail_vld) cnt_d = cnt_q - CNT_WIDTH'(1);
  end

  assign idle = (cnt_q == '0) && !core_valid_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (drain) state_d = ST_DRAIN;
      ST_DRAIN: if (!drain && idle) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      last_grant_q  <= 1'b1;
      cnt_q         <= '0;
      core_valid_q  <= 1'b0;
      core_arctan_q <= 1'b0;
      core_id_q     <= 1'b0;
      core_degree_q <= '0;
      core_x_q      <= '0;
      core_y_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_valid_q <= xfer;
      if (xfer) begin
        last_grant_q  <= sel_id;
        core_id_q     <= sel_id;
        core_arctan_q <= req_arctan_en[sel_id];
        core_degree_q <= sel_id ? req1_degree : req0_degree;
        core_x_q      <= sel_id ? req1_x : req0_x;
        core_y_q      <= sel_id ? req1_y : req0_y;
      end
    end
  end

  // Tag pipeline: entry 0 is loaded from the issue strobe. The tail
  // therefore lines up with core_valid_out exactly CORE_LATENCY cycles after
  // core_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      tag_vld_q[0] <= core_valid_q;
      tag_id_q[0]  <= core_id_q;
      for (int i = 1; i < CORE_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q  <= 2'b00;
      rsp_x_q      <= '0;
      rsp_y_q      <= '0;
      rsp_degree_q <= '0;
    end else begin
      rsp_valid_q <= 2'b00;
      if (rsp_hit) begin
        rsp_valid_q  <= tail_id ? 2'b10 : 2'b01;
        rsp_x_q      <= core_res_x;
        rsp_y_q      <= core_res_y;
        rsp_degree_q <= core_res_degree;
      end
    end
  end

`ifdef CORDIC_SCHED_TAG_CHECK_EN
  logic tag_err_q;
  // The XOR flags both mismatch kinds: a result with no tag, or a tag with
  // no result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tag_err_q <= 1'b0;
    else      tag_err_q <= tag_err_q | (core_valid_out ^ tail_vld);
  end
  assign tag_err = tag_err_q;
`else
  assign tag_err = 1'b0;
`endif

  assign core_valid     = core_valid_q;
  assign core_arctan_en = core_arctan_q;
  assign core_degree    = core_degree_q;
  assign core_x         = core_x_q;
  assign core_y         = core_y_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_x          = rsp_x_q;
  assign rsp_y          = rsp_y_q;
  assign rsp_degree     = rsp_degree_q;

endmodule

// File: tb/tb_cordic_req_scheduler.sv
module tb_cordic_req_scheduler;
  localparam int DW = 16;
  localparam int L  = 8;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid, req_ready, req_arctan_en, rsp_valid;
  logic [DW-1:0] req0_degree, req0_x, req0_y, req1_degree, req1_x, req1_y;
  logic          core_valid, core_arctan_en, core_valid_out, drain, idle, tag_err;
  logic [DW-1:0] core_degree, core_x, core_y, core_res_x, core_res_y, core_res_degree;
  logic [DW-1:0] rsp_x, rsp_y, rsp_degree;

  always #5 clk = ~clk;

  cordic_req_scheduler #(.DATA_WIDTH(DW), .CORE_LATENCY(L), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_degree(req0_degree), .req0_x(req0_x), .req0_y(req0_y),
    .req1_degree(req1_degree), .req1_x(req1_x), .req1_y(req1_y),
    .req_arctan_en(req_arctan_en), .core_valid(core_valid), .core_arctan_en(core_arctan_en),
    .core_degree(core_degree), .core_x(core_x), .core_y(core_y),
    .core_valid_out(core_valid_out), .core_res_x(core_res_x), .core_res_y(core_res_y),
    .core_res_degree(core_res_degree), .rsp_valid(rsp_valid), .rsp_x(rsp_x), .rsp_y(rsp_y),
    .rsp_degree(rsp_degree), .drain(drain), .idle(idle), .tag_err(tag_err)
  );

  typedef struct {
    logic          v;
    logic          id;
    logic          arc;
    logic [DW-1:0] deg;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
  } op_t;

  // acc[c]: request accepted in cycle c (reference); cvh[c]: what the core saw in cycle c
  op_t acc [64];
  op_t cvh [64];

  op_t           m_core;
  logic [1:0]    m_rsp_v;
  logic [DW-1:0] m_rsp_x, m_rsp_y, m_rsp_d;
  logic          m_last, m_drain, m_err, inject;
  logic [1:0]    obs_ready;
  logic [1:0]    rsp_log [$];
  int            cyc, n_chk, n_pass;

`ifdef CORDIC_SCHED_TAG_CHECK_EN
  localparam logic TAG_ERR_EXP = 1'b1;
`else
  localparam logic TAG_ERR_EXP = 1'b0;
`endif

  // Behaviour of the simulated core: fixed transform of its inputs.
  function automatic logic [DW-1:0] fx(input logic [DW-1:0] v); return v + 16'd3; endfunction
  function automatic logic [DW-1:0] fy(input logic [DW-1:0] v); return v ^ 16'h5A5A; endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
  endtask

  // Evaluated once per cycle on the falling edge: compares DUT outputs with
  // the reference, then advances the reference across the coming rising edge.
  task automatic check_cycle();
    int         k;
    op_t        t, tail;
    logic       sel, xfer, exp_idle;
    logic [1:0] exp_ready;
    k = cyc;
    if (!rst) begin
      for (int i = 0; i < 64; i++) acc[i].v = 1'b0;
      m_last = 1'b1; m_drain = 1'b0; m_err = 1'b0; m_rsp_v = 2'b00;
      m_rsp_x = '0; m_rsp_y = '0; m_rsp_d = '0;
      m_core = '{v: 1'b0, id: 1'b0, arc: 1'b0, deg: '0, x: '0, y: '0};
    end
    // Idle iff nothing was accepted in the last L+1 cycles.
    exp_idle = 1'b1;
    for (int j = 1; j <= L + 1; j++) if (acc[(k - j) & 63].v) exp_idle = 1'b0;
    sel = (req_valid == 2'b11) ? ~m_last : req_valid[1];
    exp_ready = 2'b00;
    if (rst && !m_drain && !drain && req_valid != 2'b00) exp_ready = sel ? 2'b10 : 2'b01;

    chk("req_ready", req_ready, exp_ready);
    chk("core_valid", core_valid, m_core.v);
    chk("core_arctan_en", core_arctan_en, m_core.arc);
    chk("core_degree", core_degree, m_core.deg);
    chk("core_x", core_x, m_core.x);
    chk("core_y", core_y, m_core.y);
    chk("rsp_valid", rsp_valid, m_rsp_v);
    chk("rsp_x", rsp_x, m_rsp_x);
    chk("rsp_y", rsp_y, m_rsp_y);
    chk("rsp_degree", rsp_degree, m_rsp_d);
    chk("idle", idle, exp_idle);
    chk("tag_err", tag_err, m_err);

    obs_ready = req_ready;
    if (rsp_valid != 2'b00) rsp_log.push_back(rsp_valid);
    cvh[k & 63] = '{v: core_valid, id: 1'b0, arc: core_arctan_en, deg: core_degree, x: core_x, y: core_y};

    xfer  = (exp_ready & req_valid) != 2'b00;
    t.v   = xfer;
    t.id  = sel;
    t.arc = req_arctan_en[sel];
    t.deg = sel ? req1_degree : req0_degree;
    t.x   = sel ? req1_x : req0_x;
    t.y   = sel ? req1_y : req0_y;
    acc[k & 63] = t;
    if (xfer) $display("xfer cyc=%0d id=%0d deg=%0d x=%h y=%h arc=%0d", k, sel, $signed(t.deg), t.x, t.y, t.arc);

    if (rst) begin
      tail = acc[(k - L - 1) & 63];
      if (xfer) m_core = t;
      else      m_core.v = 1'b0;
      m_rsp_v = 2'b00;
      if (tail.v && core_valid_out) begin
        m_rsp_v = tail.id ? 2'b10 : 2'b01;
        m_rsp_x = fx(tail.x); m_rsp_y = fy(tail.y); m_rsp_d = tail.deg;
      end
`ifdef CORDIC_SCHED_TAG_CHECK_EN
      if (tail.v != core_valid_out) m_err = 1'b1;
`endif
      if (xfer) m_last = sel;
      if (!m_drain && drain) m_drain = 1'b1;
      else if (m_drain && !drain && exp_idle) m_drain = 1'b0;
    end
  endtask

  task automatic tick();
    op_t c;
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    cyc++;
    c = cvh[(cyc - L) & 63];
    core_valid_out  = c.v | inject;
    core_res_x      = fx(c.x);
    core_res_y      = fy(c.y);
    core_res_degree = c.deg;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic new_op(input int i);
    logic [DW-1:0] d;
    d = DW'($urandom_range(360)) - 16'd180;
    if (i == 0) begin req0_degree = d; req0_x = DW'($urandom); req0_y = DW'($urandom); end
    else        begin req1_degree = d; req1_x = DW'($urandom); req1_y = DW'($urandom); end
    req_arctan_en[i] = $urandom_range(1);
  endtask

  typedef struct {
    logic [1:0] v;
    logic       dr;
    logic [1:0] exp_ready;
  } vec_t;

  vec_t       tbl [10];
  logic [1:0] pend;
  int         dcnt, cur;

  initial begin
    n_chk = 0; n_pass = 0; cyc = 64; inject = 1'b0; dcnt = 0;
    rst = 1'b0; req_valid = 2'b11; drain = 1'b0; req_arctan_en = 2'b00;
    req0_degree = 16'd10; req0_x = 16'd1; req0_y = 16'd2;
    req1_degree = 16'd20; req1_x = 16'd3; req1_y = 16'd4;
    core_valid_out = 1'b0; core_res_x = '0; core_res_y = '0; core_res_degree = '0;
    for (int i = 0; i < 64; i++) begin
      acc[i] = '{v: 1'b0, id: 1'b0, arc: 1'b0, deg: '0, x: '0, y: '0};
      cvh[i] = acc[i];
    end
    m_last = 1'b1; m_drain = 1'b0; m_err = 1'b0; obs_ready = 2'b00;

    // Reset state, with both requests valid during reset
    tick();
    chk("reset_ready", req_ready, 2'b00);
    chk("reset_core_valid", core_valid, 1'b0);
    chk("reset_core_degree", core_degree, 16'd0);
    chk("reset_rsp_valid", rsp_valid, 2'b00);
    chk("reset_idle", idle, 1'b1);
    chk("reset_tag_err", tag_err, 1'b0);
    tick();
    rst = 1'b1;

    // Arbitration / drain table, starting from last_grant=1
    tbl[0] = '{2'b11, 1'b0, 2'b01}; tbl[1] = '{2'b11, 1'b0, 2'b10};
    tbl[2] = '{2'b01, 1'b0, 2'b01}; tbl[3] = '{2'b01, 1'b0, 2'b01};
    tbl[4] = '{2'b11, 1'b0, 2'b10}; tbl[5] = '{2'b10, 1'b0, 2'b10};
    tbl[6] = '{2'b11, 1'b0, 2'b01}; tbl[7] = '{2'b00, 1'b0, 2'b00};
    tbl[8] = '{2'b11, 1'b1, 2'b00}; tbl[9] = '{2'b11, 1'b0, 2'b00};
    for (int i = 0; i < 10; i++) begin
      req_valid = tbl[i].v; drain = tbl[i].dr;
      tick();
      chk($sformatf("table_row%0d_ready", i), obs_ready, tbl[i].exp_ready);
    end
    req_valid = 2'b00; drain = 1'b0;
    repeat (L + 4) tick();

    // Single request: deg=45 from requester 0
    do_reset();
    req_valid = 2'b01; req0_degree = 16'd45; req_arctan_en = 2'b00;
    tick();
    chk("single_grant", obs_ready, 2'b01);
    chk("single_core_valid", core_valid, 1'b1);
    chk("single_core_degree", core_degree, 16'd45);
    req_valid = 2'b00;
    repeat (L) tick();
    chk("single_rsp_not_early", rsp_valid, 2'b00);
    tick();
    chk("single_rsp_valid", rsp_valid, 2'b01);
    chk("single_rsp_degree", rsp_degree, 16'd45);
    tick();
    chk("single_rsp_one_cycle", rsp_valid, 2'b00);

    // Contention: both valid for 6 cycles
    do_reset(); rsp_log.delete();
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("contend_grant", obs_ready, (i % 2) ? 2'b10 : 2'b01);
    end
    req_valid = 2'b00;
    repeat (L + 3) tick();
    chk("contend_rsp_count", rsp_log.size(), 6);
    for (int i = 0; i < rsp_log.size(); i++)
      chk("contend_rsp_order", rsp_log[i], (i % 2) ? 2'b10 : 2'b01);

    // Drain: grants in cycles 0..4, drain from cycle 5
    do_reset(); rsp_log.delete();
    req_valid = 2'b11;
    repeat (5) tick();
    drain = 1'b1;
    tick();
    chk("drain_same_cycle", obs_ready, 2'b00);
    cur = 6;
    while (cur < 5 + L + 1) begin
      if (cur == 5 + L) chk("drain_not_idle_yet", idle, 1'b0);
      tick(); cur++;
      chk("drain_no_grant", obs_ready, 2'b00);
    end
    chk("drain_idle", idle, 1'b1);
    tick();
    chk("drain_rsp_count", rsp_log.size(), 5);
    drain = 1'b0;
    tick();
    chk("drain_release_cycle", obs_ready, 2'b00);
    tick();
    chk("drain_resume_grant", obs_ready, 2'b10);
    req_valid = 2'b00;
    repeat (L + 4) tick();

    // Randomized traffic against the reference
    for (int n = 0; n < 600; n++) begin
      pend = req_valid & ~obs_ready;
      for (int i = 0; i < 2; i++)
        if (!pend[i]) begin
          req_valid[i] = ($urandom_range(3) != 0);
          new_op(i);
        end
      if (dcnt > 0) dcnt--;
      else if ($urandom_range(50) == 0) dcnt = $urandom_range(12, 2);
      drain = (dcnt > 0);
      tick();
    end
    req_valid = 2'b00; drain = 1'b0;
    repeat (L + 4) tick();

    // Reset mid-flight: 3 requests, then 2 reset cycles
    do_reset(); rsp_log.delete();
    req_valid = 2'b01;
    repeat (3) tick();
    req_valid = 2'b00;
    tick();
    rst = 1'b0; req_valid = 2'b01;
    #1;
    chk("midrst_ready", req_ready, 2'b00);
    chk("midrst_idle", idle, 1'b1);
    chk("midrst_core_valid", core_valid, 1'b0);
    chk("midrst_core_x", core_x, 16'd0);
    tick(); tick();
    rst = 1'b1; req_valid = 2'b00;
    repeat (L + 6) tick();
    chk("midrst_no_rsp", rsp_log.size(), 0);
    chk("midrst_idle_after", idle, 1'b1);
    chk("midrst_tag_err", tag_err, TAG_ERR_EXP);

    // Spurious core result with no tags in flight
    do_reset(); rsp_log.delete();
    repeat (L + 2) tick();
    inject = 1'b1;
    tick();
    inject = 1'b0;
    tick();
    chk("inject_tag_err", tag_err, TAG_ERR_EXP);
    repeat (4) tick();
    chk("inject_tag_err_sticky", tag_err, TAG_ERR_EXP);
    chk("inject_no_rsp", rsp_log.size(), 0);

    // Boundary operands from requester 1
    do_reset(); rsp_log.delete();
    req_valid = 2'b10; req1_degree = 16'hFF4C; req1_x = 16'h1234; req1_y = 16'h0042;
    req_arctan_en = 2'b10;
    tick();
    chk("bound_m180_degree", core_degree, 16'hFF4C);
    chk("bound_m180_arctan", core_arctan_en, 1'b1);
    req1_degree = 16'd180; req1_x = 16'hFFFF; req1_y = 16'h0000; req_arctan_en = 2'b00;
    tick();
    chk("bound_180_degree", core_degree, 16'd180);
    chk("bound_180_x", core_x, 16'hFFFF);
    chk("bound_180_y", core_y, 16'h0000);
    req_valid = 2'b00;
    repeat (L + 3) tick();
    chk("bound_rsp_count", rsp_log.size(), 2);
    for (int i = 0; i < rsp_log.size(); i++) chk("bound_rsp_route", rsp_log[i], 2'b10);
    chk("bound_rsp_degree", rsp_degree, 16'd180);
    chk("bound_rsp_x", rsp_x, 16'h0002);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
